// File: rtl/weight_rd_arbiter.sv
// Two-requester (CONV/FC) weight SRAM burst read arbiter with round-robin tie break.
// Grant and first beat come 1 cycle after the request; rvalid trails each read strobe by 1 cycle.
module weight_rd_arbiter #(
  parameter int WEIGHT_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         conv_req,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] conv_addr,
  input  logic [LEN_WIDTH-1:0]         conv_len,
  input  logic                         fc_req,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] fc_addr,
  input  logic [LEN_WIDTH-1:0]         fc_len,
  output logic                         conv_gnt,
  output logic                         fc_gnt,
  output logic                         conv_rvalid,
  output logic                         fc_rvalid,
  output logic                         conv_burst_done,
  output logic                         fc_burst_done,
  output logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight,
  output logic                         sram_ren,
  output logic                         busy,
  output logic                         owner
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;
  localparam logic [LEN_WIDTH-1:0]         LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WEIGHT_ADDR_WIDTH-1:0] ADDR_ONE = {{(WEIGHT_ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]                   state_q, state_d;
  logic                         last_owner_q, last_owner_d;
  logic                         owner_q, owner_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]         len_q, len_d;
  logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         conv_gnt_q, conv_gnt_d;
  logic                         fc_gnt_q, fc_gnt_d;
  logic                         rvalid_q, rvalid_d;
  logic                         rv_owner_q, rv_owner_d;
  logic                         rv_last_q, rv_last_d;

  logic conv_elig, fc_elig, win_fc, in_burst, beat_last;

  assign conv_elig = conv_req && (conv_len != '0);
  assign fc_elig   = fc_req && (fc_len != '0);
  // On a tie the requester that did not win last time gets the grant.
  assign win_fc    = fc_elig && (!conv_elig || !last_owner_q);
  assign in_burst  = (state_q == S_BURST);
  assign beat_last = (cnt_q == (len_q - LEN_ONE));

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    conv_gnt_d   = 1'b0;
    fc_gnt_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (conv_elig || fc_elig) begin
          state_d      = S_BURST;
          owner_d      = win_fc;
          last_owner_d = win_fc;
          addr_d       = win_fc ? fc_addr : conv_addr;
          len_d        = win_fc ? fc_len : conv_len;
          cnt_d        = '0;
          conv_gnt_d   = !win_fc;
          fc_gnt_d     = win_fc;
        end
      end
      default: begin
        if (beat_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + LEN_ONE;
          addr_d = addr_q + ADDR_ONE;
        end
      end
    endcase
    // Routing uses the owner captured alongside the read, not the live owner.
    rvalid_d   = in_burst;
    rv_owner_d = owner_q;
    rv_last_d  = in_burst && beat_last;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      conv_gnt_q   <= 1'b0;
      fc_gnt_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rv_owner_q   <= 1'b0;
      rv_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      conv_gnt_q   <= conv_gnt_d;
      fc_gnt_q     <= fc_gnt_d;
      rvalid_q     <= rvalid_d;
      rv_owner_q   <= rv_owner_d;
      rv_last_q    <= rv_last_d;
    end
  end

  assign conv_gnt          = conv_gnt_q;
  assign fc_gnt            = fc_gnt_q;
  assign conv_rvalid       = rvalid_q && !rv_owner_q;
  assign fc_rvalid         = rvalid_q && rv_owner_q;
  assign conv_burst_done   = conv_rvalid && rv_last_q;
  assign fc_burst_done     = fc_rvalid && rv_last_q;
  assign sram_ren          = in_burst;
  assign sram_raddr_weight = in_burst ? addr_q : '0;
  assign busy              = in_burst;
  assign owner             = owner_q;

endmodule

// File: tb/tb_weight_rd_arbiter.sv
// Bench for weight_rd_arbiter: directed table, corner sequences, and random traffic
// checked every cycle against a transaction-level schedule of expected outputs.
module tb_weight_rd_arbiter;
  localparam int AW = 15;
  localparam int LW = 8;
  localparam int N  = 16384;

  logic clk = 1'b0;
  logic srst;
  logic conv_req, fc_req;
  logic [AW-1:0] conv_addr, fc_addr;
  logic [LW-1:0] conv_len, fc_len;
  logic conv_gnt, fc_gnt, conv_rvalid, fc_rvalid, conv_burst_done, fc_burst_done;
  logic [AW-1:0] sram_raddr_weight;
  logic sram_ren, busy, owner;

  weight_rd_arbiter #(.WEIGHT_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .srst(srst),
    .conv_req(conv_req), .conv_addr(conv_addr), .conv_len(conv_len),
    .fc_req(fc_req), .fc_addr(fc_addr), .fc_len(fc_len),
    .conv_gnt(conv_gnt), .fc_gnt(fc_gnt),
    .conv_rvalid(conv_rvalid), .fc_rvalid(fc_rvalid),
    .conv_burst_done(conv_burst_done), .fc_burst_done(fc_burst_done),
    .sram_raddr_weight(sram_raddr_weight), .sram_ren(sram_ren),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  int cyc     = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: each grant schedules its whole burst onto a per-cycle timeline.
  bit e_cg [N], e_fg [N], e_ren [N], e_busy [N], e_own [N];
  bit e_rv [N], e_rvo [N], e_done [N];
  int e_addr [N];
  bit m_last = 1'b1;
  int m_free = 0;

  task automatic model_step(input int c);
    bit ce, fe, w;
    int a, l;
    if (srst) begin
      for (int i = c + 1; i < c + 300 && i < N; i++) begin
        e_cg[i] = 0; e_fg[i] = 0; e_ren[i] = 0; e_busy[i] = 0; e_own[i] = 0;
        e_rv[i] = 0; e_rvo[i] = 0; e_done[i] = 0; e_addr[i] = 0;
      end
      m_last = 1'b1;
      m_free = c + 1;
    end else if (c >= m_free) begin
      ce = conv_req && (conv_len != 0);
      fe = fc_req && (fc_len != 0);
      if (ce || fe) begin
        w = (ce && fe) ? !m_last : fe;
        a = w ? int'(fc_addr) : int'(conv_addr);
        l = w ? int'(fc_len) : int'(conv_len);
        if (w) e_fg[c+1] = 1; else e_cg[c+1] = 1;
        for (int k = 0; k < l; k++) begin
          e_ren[c+1+k]  = 1;
          e_busy[c+1+k] = 1;
          e_own[c+1+k]  = w;
          e_addr[c+1+k] = (a + k) % (1 << AW);
          e_rv[c+2+k]   = 1;
          e_rvo[c+2+k]  = w;
        end
        e_done[c+1+l] = 1;
        m_last = w;
        m_free = c + l + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] act, exp;
    if (mon_en) begin
      act = {conv_gnt, fc_gnt, conv_rvalid, fc_rvalid, conv_burst_done, fc_burst_done,
             sram_ren, busy, sram_raddr_weight, busy & owner};
      exp = {e_cg[cyc], e_fg[cyc], e_rv[cyc] & !e_rvo[cyc], e_rv[cyc] & e_rvo[cyc],
             e_done[cyc] & e_rv[cyc] & !e_rvo[cyc], e_done[cyc] & e_rv[cyc] & e_rvo[cyc],
             e_ren[cyc], e_busy[cyc], 15'(e_addr[cyc]), e_busy[cyc] & e_own[cyc]};
      chk($sformatf("cycle%0d outputs", cyc), longint'(act), longint'(exp));
    end
    model_step(cyc);
    cyc++;
  end

  task automatic set_in(input bit rst, input bit cr, input int ca, input int cl,
                        input bit fr, input int fa, input int fl);
    @(posedge clk);
    #1;
    srst = rst; conv_req = cr; conv_addr = AW'(ca); conv_len = LW'(cl);
    fc_req = fr; fc_addr = AW'(fa); fc_len = LW'(fl);
  endtask

  task automatic idle_cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    set_in(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk({tag, " reset outputs"},
        longint'({conv_gnt, fc_gnt, conv_rvalid, fc_rvalid, conv_burst_done, fc_burst_done,
                  sram_ren, busy, owner, sram_raddr_weight}), 0);
  endtask

  typedef struct {
    bit cr; int ca; int cl;
    bit fr; int fa; int fl;
    bit exp_cg; bit exp_fg; int exp_addr;
  } vec_t;

  vec_t tbl [8];
  int gq [$];
  int rv_cnt, done_cnt;

  initial begin
    srst = 1; conv_req = 0; fc_req = 0; conv_addr = 0; fc_addr = 0; conv_len = 0; fc_len = 0;
    repeat (2) @(posedge clk);
    #1 srst = 0;
    mon_en = 1;

    tbl[0] = '{1, 'h0010, 3, 0, 0, 0, 1, 0, 'h0010};
    tbl[1] = '{0, 0, 0, 1, 'h7FFE, 4, 0, 1, 'h7FFE};
    tbl[2] = '{1, 'h0123, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 'h0100, 2, 1, 'h0200, 2, 1, 0, 'h0100};
    tbl[4] = '{1, 'h0300, 0, 1, 'h0055, 1, 0, 1, 'h0055};
    tbl[5] = '{1, 'h0001, 0, 1, 'h0002, 0, 0, 0, 0};
    tbl[6] = '{0, 'h1234, 5, 1, 'h0AAA, 2, 0, 1, 'h0AAA};
    tbl[7] = '{1, 'h7FFF, 1, 0, 'h0BBB, 7, 1, 0, 'h7FFF};

    for (int i = 0; i < 8; i++) begin
      do_reset($sformatf("vec%0d", i));
      set_in(0, tbl[i].cr, tbl[i].ca, tbl[i].cl, tbl[i].fr, tbl[i].fa, tbl[i].fl);
      idle_cyc();
      chk($sformatf("vec%0d gnt", i), longint'({conv_gnt, fc_gnt}),
          longint'({tbl[i].exp_cg, tbl[i].exp_fg}));
      chk($sformatf("vec%0d raddr", i), longint'(sram_raddr_weight), longint'(tbl[i].exp_addr));
      chk($sformatf("vec%0d busy", i), longint'({busy, sram_ren}),
          longint'({2{tbl[i].exp_cg | tbl[i].exp_fg}}));
      repeat (8) idle_cyc();
    end

    // Single CONV burst of 3: beat addresses, trailing rvalid and done
    do_reset("burst3");
    set_in(0, 1, 'h0010, 3, 0, 0, 0);
    idle_cyc();
    chk("burst3 t1", longint'({conv_gnt, sram_ren, sram_raddr_weight, conv_rvalid}),
        longint'({1'b1, 1'b1, 15'h0010, 1'b0}));
    idle_cyc();
    chk("burst3 t2", longint'({conv_gnt, sram_raddr_weight, conv_rvalid}),
        longint'({1'b0, 15'h0011, 1'b1}));
    idle_cyc();
    chk("burst3 t3", longint'({sram_raddr_weight, conv_rvalid, conv_burst_done}),
        longint'({15'h0012, 1'b1, 1'b0}));
    idle_cyc();
    chk("burst3 t4", longint'({sram_ren, conv_rvalid, conv_burst_done, fc_rvalid}),
        longint'(4'b0110));

    // Reset during beat 2 of a 5-beat burst, then a tie goes to CONV
    do_reset("midrst");
    set_in(0, 1, 'h0020, 5, 0, 0, 0);
    idle_cyc();
    idle_cyc();
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst beat2 addr", longint'(sram_raddr_weight), 'h22);
    set_in(0, 1, 'h0400, 2, 1, 'h0500, 2);
    @(negedge clk);
    chk("midrst after", longint'({sram_ren, busy, conv_rvalid, fc_rvalid}), 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst tie gnt", longint'({conv_gnt, fc_gnt, conv_rvalid, fc_rvalid}), longint'(4'b1000));
    repeat (8) idle_cyc();

    // Both held continuously with len 1: grants alternate
    do_reset("alt");
    gq.delete();
    for (int i = 0; i < 16; i++) begin
      set_in(0, 1, 'h0600 + i, 1, 1, 'h0700 + i, 1);
      @(negedge clk);
      if (conv_gnt) gq.push_back(0);
      if (fc_gnt) gq.push_back(1);
    end
    chk("alt grant count>=4", longint'(gq.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt grant%0d", i), (gq.size() > i) ? longint'(gq[i]) : -1, longint'(i % 2));
    repeat (4) idle_cyc();

    // Maximum length burst
    do_reset("len255");
    set_in(0, 1, 'h7F80, 255, 0, 0, 0);
    rv_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 262; i++) begin
      idle_cyc();
      if (conv_rvalid) rv_cnt++;
      if (conv_burst_done) done_cnt++;
    end
    chk("len255 rvalid beats", longint'(rv_cnt), 255);
    chk("len255 done pulses", longint'(done_cnt), 1);

    // Random traffic against the reference timeline
    do_reset("rand");
    for (int i = 0; i < 4000; i++) begin
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0) ? 'h7FFC : int'($urandom_range(0, 'h7FFF)),
             int'($urandom_range(0, 6)),
             ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0) ? 'h7FFD : int'($urandom_range(0, 'h7FFF)),
             int'($urandom_range(0, 6)));
    end
    repeat (10) idle_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_rd_arbiter.md
WEIGHT_RD_ARBITER -- requirements
Module: weight_rd_arbiter

Interface
REQ-001 SHALL have parameter WEIGHT_ADDR_WIDTH, default 15, width of the weight SRAM read address.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of the burst-length field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port srst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports conv_req / fc_req  input  1  burst request from CONV / FC requester.
REQ-006 SHALL have ports conv_addr / fc_addr  input  WEIGHT_ADDR_WIDTH  burst start address.
REQ-007 SHALL have ports conv_len / fc_len  input  LEN_WIDTH  burst length in beats.
REQ-008 SHALL have ports conv_gnt / fc_gnt  output  1  one-cycle pulse: burst accepted.
REQ-009 SHALL have ports conv_rvalid / fc_rvalid  output  1  sram_rdata_weight holds a valid beat for that requester.
REQ-010 SHALL have ports conv_burst_done / fc_burst_done  output  1  one-cycle pulse coincident with the last rvalid.
REQ-011 SHALL have port sram_raddr_weight  output  WEIGHT_ADDR_WIDTH  weight SRAM read address.
REQ-012 SHALL have port sram_ren  output  1  weight SRAM read strobe.
REQ-013 SHALL have port busy  output  1  high in BURST state.
REQ-014 SHALL have port owner  output  1  0 = CONV, 1 = FC; meaningful while busy or rvalid.

Function
REQ-015 SHALL implement states IDLE and BURST; reset state IDLE.
REQ-016 In IDLE, a requester is eligible when its req=1 and len!=0; a request with len=0 SHALL be ignored (no gnt, stays IDLE).
REQ-017 With one eligible requester in IDLE at cycle t, the arbiter SHALL latch its addr/len, set owner, and enter BURST at t+1.
REQ-018 With both eligible, the requester not recorded in last_owner SHALL win; last_owner resets to FC, so CONV wins the first tie.
REQ-019 last_owner SHALL update to the winner at each grant.
REQ-020 The winner's gnt SHALL be high exactly in cycle t+1, registered, never both gnt high.
REQ-021 In BURST, beat k (k=0..len-1) SHALL drive sram_ren=1 and sram_raddr_weight=start+k at cycle t+1+k.
REQ-022 Address increment SHALL wrap modulo 2^WEIGHT_ADDR_WIDTH.
REQ-023 After the beat k=len-1 cycle, state SHALL return to IDLE; IDLE SHALL sample requests in that next cycle (one idle gap between bursts).
REQ-024 Requests SHALL be ignored during BURST; a requester SHALL drop req the cycle after gnt, else a still-high req in the next IDLE is a new request.
REQ-025 Owner's rvalid SHALL assert one cycle after each sram_ren (SRAM read latency 1); the other requester's rvalid SHALL stay 0.
REQ-026 rvalid routing SHALL use a pipelined copy of owner, so a new grant cannot misroute a trailing beat.
REQ-027 burst_done SHALL pulse with the rvalid of beat len-1.
REQ-028 In IDLE, sram_ren=0 and sram_raddr_weight=0.
REQ-029 Beat counter SHALL be LEN_WIDTH bits; len=2^LEN_WIDTH-1 SHALL be supported without overflow.

Reset
REQ-030 On srst=1 at any edge, including mid-burst, next cycle: state IDLE, all gnt/rvalid/burst_done/sram_ren/busy=0, sram_raddr_weight=0, owner=0, last_owner=FC, counter=0.
REQ-031 Beats issued before reset SHALL NOT produce rvalid after reset.

Verification
REQ-032 CONV req addr=0x0010 len=3 at t -> conv_gnt t+1; raddr 0x10,0x11,0x12 at t+1..t+3; conv_rvalid t+2..t+4; conv_burst_done t+4.
REQ-033 Both req (len 2) at first cycle after reset -> CONV granted first; FC gnt in the cycle after CONV's IDLE gap; FC rvalid only on FC beats.
REQ-034 FC req addr=0x7FFE len=4 -> raddr 0x7FFE,0x7FFF,0x0000,0x0001.
REQ-035 CONV req len=0 -> no gnt, busy stays 0, sram_ren stays 0.
REQ-036 srst during beat 2 of a len=5 burst -> next cycle sram_ren=0, busy=0, no further rvalid; subsequent tie grants CONV.
REQ-037 Both reqs held continuously (len 1) -> grants alternate CONV, FC, CONV, FC.
